// File: rtl/seq_scan_pkg.sv
// Shared types and reset-default configuration for the serial pattern scanner.
package seq_scan_pkg;

    // Scheduler states: waiting for a word, or shifting one out bit by bit.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Detector configuration loaded at reset: pattern 1011, length 4, overlapping.
    localparam logic [31:0] DEF_PATTERN = 32'b1011;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Width needed to hold a pattern length in the range 0..pat_max.
    function automatic int len_w(input int pat_max);
        return $clog2(pat_max + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Programmable Moore pattern detector: bit history, fill count, compare, match register.
module seq_match_core
    import seq_scan_pkg::*;
#(
    parameter int PAT_MAX = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_vld,
    input  logic                          bit_in,
    input  logic                          clr,
    input  logic [PAT_MAX-1:0]            pattern,
    input  logic [len_w(PAT_MAX)-1:0]     len,
    input  logic                          overlap,
    output logic                          hit,
    output logic                          match
);

    localparam int LEN_W = len_w(PAT_MAX);

    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;

    logic [PAT_MAX-1:0] hist_next;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic               full;
    logic               hit_w;

    // Compare the history including the incoming bit against the low len pattern bits.
    always_comb begin
        hist_next = (hist_q << 1) | PAT_MAX'(bit_in);
        mask      = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        fill_inc = {1'b0, fill_q} + (LEN_W+1)'(1);
        full     = (fill_inc >= {1'b0, len});
        hit_w    = bit_vld && !clr && full && (((hist_next ^ pattern) & mask) == '0);
    end

    // Next history/fill/match: config clear wins, otherwise consume the serial bit.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_vld) begin
            match_d = hit_w;
            if (hit_w && !overlap) begin
                // Non-overlapping mode restarts the search from an empty history.
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_next;
                fill_d = full ? len : fill_inc[LEN_W-1:0];
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign hit   = hit_w;
    assign match = match_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit scheduler feeding a programmable pattern detector, with a saturating match counter.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          cfg_we,
    input  logic [PAT_MAX-1:0]            cfg_pattern,
    input  logic [len_w(PAT_MAX)-1:0]     cfg_len,
    input  logic                          cfg_overlap,
    output logic                          cfg_err,
    input  logic                          count_clr,
    output logic                          busy,
    output logic                          ser_bit,
    output logic                          match,
    output logic [CNT_W-1:0]              match_count,
    output logic                          sat
);

    localparam int LEN_W = len_w(PAT_MAX);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic               last_bit;
    logic               accept;
    logic               cfg_ok;
    logic               hit;

    // Handshake and serial output derived from the current scheduler state.
    always_comb begin
        last_bit = (state_q == SHIFT) && (idx_q == '0);
        in_ready = (state_q == IDLE) || last_bit;
        accept   = in_valid && in_ready;
        busy     = (state_q == SHIFT);
        ser_bit  = busy ? shreg_q[idx_q] : 1'b0;
    end

    // Scheduler FSM: load a word, walk the index down, reload on the last bit without a bubble.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    idx_d   = IDX_W'(DATA_W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    if (accept) begin
                        shreg_d = in_data;
                        idx_d   = IDX_W'(DATA_W - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Configuration writes only land between words; anything else is flagged next cycle.
    always_comb begin
        cfg_ok    = cfg_we && (state_q == IDLE) && !accept &&
                    (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
        cfg_err_d = cfg_we && !cfg_ok;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        if (cfg_ok) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
        end
    end

    // Saturating match counter; clear beats a same-edge increment.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (count_clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (hit) begin
            if (&cnt_q) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Scheduler, configuration and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            pat_q     <= PAT_MAX'(DEF_PATTERN);
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVERLAP;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    seq_match_core #(
        .PAT_MAX (PAT_MAX)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .bit_vld (busy),
        .bit_in  (ser_bit),
        .clr     (cfg_ok),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .hit     (hit),
        .match   (match)
    );

    assign cfg_err     = cfg_err_q;
    assign match_count = cnt_q;
    assign sat         = sat_q;

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Word-to-bit scheduler and programmable Moore pattern detector for serial-pattern scanning.
- Accepts parallel words over a valid/ready handshake and serialises each word MSB-first, one bit per clock, into an internal detector.
- The detector has a programmable pattern (reset default 1011, overlapping), and the block counts matches.
- Sits between a word-oriented producer (bus or FIFO) and status/interrupt logic; configuration writes are sequenced so they never land mid-word.

Parameters:
- DATA_W, 8, bits per input word; must be >= 1.
- PAT_MAX, 8, maximum pattern length in bits.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  word; bit DATA_W-1 is sent first.
- cfg_we  input  1  configuration write strobe.
- cfg_pattern  input  PAT_MAX  pattern; the low cfg_len bits are used, and bit cfg_len-1 is the first bit to match.
- cfg_len  input  $clog2(PAT_MAX+1)  pattern length; legal range 1..PAT_MAX.
- cfg_overlap  input  1  1 = overlapping matches, 0 = history cleared after each match.
- cfg_err  output  1  one-cycle pulse when a cfg_we write is rejected.
- count_clr  input  1  synchronous clear of match_count and sat.
- busy  output  1  high while in SHIFT.
- ser_bit  output  1  bit currently fed to the detector (valid while busy).
- match  output  1  Moore output; high for one cycle after the completing bit.
- match_count  output  CNT_W  number of matches, saturating.
- sat  output  1  sticky; set when match_count is at all-ones and another match occurs.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - State is IDLE; in_ready=1, busy=0, ser_bit=0.
  - match=0, match_count=0, sat=0, cfg_err=0.
  - Pattern = ...1011, len=4, overlap=1.
  - Detector history and fill count are 0.
- Scheduler FSM:
  - IDLE: in_ready=1. When in_valid&in_ready, latch in_data into the shift register, set bit index = DATA_W-1, and go to SHIFT.
  - SHIFT: each cycle, present shreg[idx] on ser_bit; the detector consumes it at the next edge, then idx decrements.
  - On the last bit (idx=0), in_ready=1. If in_valid, the next word loads with no bubble and the FSM stays in SHIFT. Otherwise it returns to IDLE.
  - A word accepted at edge E0 has its bits consumed at edges E1..E_DATA_W.
- Detector:
  - hist is shifted left with the new bit at the LSB. fill saturates at cfg_len and counts bits consumed since the last clear.
  - A hit occurs when fill (including the new bit) >= cfg_len and the low cfg_len bits of hist equal the pattern.
  - match is registered: it is high in the cycle after the edge consuming the completing bit, and match_count increments on that same edge.
  - History persists across word boundaries, so patterns can span words.
  - With overlap=0, a hit clears hist and fill on the same edge.
- Counter:
  - Saturates at all-ones; a hit while saturated sets sat.
  - count_clr has priority over an increment on the same edge.
- Configuration:
  - cfg_we is accepted only when state=IDLE, no word is accepted that cycle, and 1<=cfg_len<=PAT_MAX.
  - An accepted write updates the pattern, length and overlap, and clears hist, fill and match.
  - An accepted write does not clear match_count.
  - Any other cfg_we gives a cfg_err pulse on the next cycle, and the configuration is unchanged.
- Reset mid-word: the word in progress is discarded immediately and all outputs return to their reset values.

Decomposition:
- Shared package seq_scan_pkg holds:
  - state enum {IDLE, SHIFT};
  - default pattern constant (1011), default length (4), default overlap (1);
  - LEN_W = $clog2(PAT_MAX+1).
- One sub-module, seq_match_core: the programmable detector (hist, fill, compare, match register).
- The FSM, serialiser and counter live in the top level.

Test Plan:
- Reset defaults, then in_data=0xB0 → match high in the cycle after E4 only; match_count=1; in_ready=1 again after E8.
- in_data=0xB6 with overlap=1 → matches after E4 and E7, count=2. Reload with overlap=0 → match only after E4, count +1.
- Back-to-back 0x01 then 0x60 with in_valid held high → no idle cycle between the words, and one match on the third bit of the second word (cross-word).
- cfg_we during SHIFT, and cfg_we with cfg_len=0 → cfg_err pulse each time, with configuration and behaviour unchanged. A legal write of pattern 110, len 3 followed by 0xDB → 2 matches with overlap=1.
- CNT_W=2, feed 0xBB twice → count stops at 3 and sat=1. Then count_clr → count=0, sat=0.
- Assert reset at E3 of a word → outputs go to reset values immediately; after release, 0xB0 gives a single match.
